// File: rtl/jk_bank_ctrl.sv
// Arbitrated command controller for a W-bit JK register bank.
// Two requesters issue masked HOLD/CLEAR/SET/TOGGLE commands via REQ/ACK.

package jk_bank_ctrl_pkg;
  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_RESP  = 2'b10
  } state_e;
endpackage

module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  INIT = '0
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            EN,
  input  logic            REQ_A,
  input  logic [OP_W-1:0] OP_A,
  input  logic [W-1:0]    MASK_A,
  output logic            ACK_A,
  input  logic            REQ_B,
  input  logic [OP_W-1:0] OP_B,
  input  logic [W-1:0]    MASK_B,
  output logic            ACK_B,
  output logic [W-1:0]    Q,
  output logic            BUSY,
  output logic            GNT_ID
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    mask_q, mask_d;
  logic [W-1:0]    q_q, q_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            ack_a_q, ack_a_d;
  logic            ack_b_q, ack_b_d;

  logic            win_b;
  logic            j_bit, k_bit;
  logic [W-1:0]    j_vec, k_vec;
  logic [W-1:0]    bank_next;

  // Round robin: with both requesting, the one that did not go last wins.
  assign win_b = REQ_B & (~REQ_A | ~last_q);

  // Opcode to shared J/K drive for the latched command.
  always_comb begin
    j_bit = 1'b0;
    k_bit = 1'b0;
    case (op_e'(op_q))
      OP_CLEAR:  k_bit = 1'b1;
      OP_SET:    j_bit = 1'b1;
      OP_TOGGLE: begin
        j_bit = 1'b1;
        k_bit = 1'b1;
      end
      default: begin
        j_bit = 1'b0;
        k_bit = 1'b0;
      end
    endcase
  end

  // Mask acts as per-bit CE: unmasked bits see J=K=0 and hold.
  assign j_vec     = {W{j_bit}} & mask_q;
  assign k_vec     = {W{k_bit}} & mask_q;
  assign bank_next = (j_vec & ~q_q) | (~k_vec & q_q);

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      q_q     <= INIT;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  // Sequencing: IDLE grants and latches, APPLY writes bank and acks, RESP retires.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_a_d = ack_a_q;
    ack_b_d = ack_b_q;
    if (EN) begin
      case (state_q)
        ST_IDLE: begin
          if (REQ_A || REQ_B) begin
            gnt_d   = win_b;
            op_d    = win_b ? OP_B : OP_A;
            mask_d  = win_b ? MASK_B : MASK_A;
            state_d = ST_APPLY;
          end
        end
        ST_APPLY: begin
          q_d     = bank_next;
          ack_a_d = ~gnt_q;
          ack_b_d = gnt_q;
          state_d = ST_RESP;
        end
        ST_RESP: begin
          ack_a_d = 1'b0;
          ack_b_d = 1'b0;
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign Q      = q_q;
  assign ACK_A  = ack_a_q;
  assign ACK_B  = ack_b_q;
  assign GNT_ID = gnt_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command controller for a W-bit register bank with per-bit JK semantics.
- Two requesters (A, B) each issue masked commands: HOLD, CLEAR, SET or TOGGLE.
- A round-robin arbiter shares the bank between them; each requester sees a REQ/ACK handshake.
- Sits between control logic and the JK storage bank, driving each bit's J/K/CE through one sequencing FSM.

Parameters:
W, 8, bank width in bits (>=1).
INIT, 0 (W bits), value loaded into Q on reset.

Ports:
CLK  input  1  clock; all state changes on rising edge.
R  input  1  reset, asynchronous, active-high.
EN  input  1  global enable; low freezes FSM and bank.
REQ_A  input  1  requester A command request.
OP_A  input  2  A opcode: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE.
MASK_A  input  W  A bit select; 1 = bit affected.
ACK_A  output  1  A command completed (one-cycle pulse).
REQ_B  input  1  requester B command request.
OP_B  input  2  B opcode, same encoding.
MASK_B  input  W  B bit select.
ACK_B  output  1  B command completed (one-cycle pulse).
Q  output  W  bank contents.
BUSY  output  1  high when FSM is not in IDLE.
GNT_ID  output  1  requester owning the current/last command: 0 = A, 1 = B.

Behaviour:
- Reset (R=1, asynchronous, no clock needed):
  - Q=INIT, FSM=IDLE, ACK_A=ACK_B=0, BUSY=0, GNT_ID=0.
  - Round-robin pointer LAST=B, so A wins the first contention.
- FSM states and transitions (only when EN=1):
  - IDLE: if any REQ is high, arbitrate, latch the winner's OP/MASK into command registers, set GNT_ID, go to APPLY. Otherwise stay.
  - APPLY: on the edge leaving APPLY, update Q from the latched command, set ACK of the granted requester, go to RESP.
  - RESP: clear ACK, set LAST=GNT_ID, go to IDLE.
- Per-bit update in APPLY, for masked bits (CE=1, J/K from OP):
  - HOLD (J=0,K=0): bit keeps its value.
  - CLEAR (J=0,K=1): bit becomes 0.
  - SET (J=1,K=0): bit becomes 1.
  - TOGGLE (J=1,K=1): bit is inverted.
  - Unmasked bits (CE=0) always hold.
- Latency and throughput:
  - REQ sampled at edge e1; new Q and ACK both visible after edge e2; ACK drops after e3.
  - One command per 3 cycles.
- Handshake:
  - Requester holds REQ, OP and MASK stable until it samples ACK=1, then deasserts REQ before the next IDLE sample.
  - OP/MASK are latched at grant; later changes are ignored for that command.
  - HOLD and MASK=0 commands are still granted and acknowledged.
- Arbitration:
  - Only one REQ high: that requester is granted.
  - Both high: grant the requester not equal to LAST.
  - Two back-to-back contending requesters therefore alternate A, B, A, ...
- EN=0: FSM, Q, ACK, LAST and GNT_ID all hold their values, including an ACK already high. Resumes exactly where it stopped when EN returns to 1.
- Reset mid-command (R=1 in APPLY or RESP):
  - Command is discarded with no ACK, and Q=INIT.
  - A requester still holding REQ is re-arbitrated from IDLE after R falls.
- BUSY is combinational from state (APPLY or RESP).

Test Plan:
1. W=8, INIT=0x00; pulse R high between clock edges -> Q=0x00, ACK_A=ACK_B=0 and BUSY=0 immediately, without waiting for an edge.
2. REQ_A, OP_A=10, MASK_A=0xA5 sampled at e1 -> after e2 Q=0xA5, ACK_A=1, GNT_ID=0; after e3 ACK_A=0, BUSY=0.
3. From Q=0xA5: A issues TOGGLE 0x0F -> Q=0xAA; then CLEAR 0x80 -> Q=0x2A; then HOLD 0xFF -> Q=0x2A and ACK_A still pulses.
4. REQ_A and REQ_B held high continuously, each dropped for one cycle after its ACK and then reasserted -> grant order A, B, A, B (GNT_ID 0,1,0,1); exactly one ACK per command.
5. B SET 0x01 with EN=0 for 3 cycles while in APPLY -> Q unchanged, no ACK_B, BUSY=1; EN=1 -> Q bit0=1 and ACK_B on the following edge.
6. A TOGGLE 0xFF with R asserted during APPLY (INIT=0x3C) -> Q=0x3C, no ACK_A; R released with REQ_A still high -> command re-granted, Q=0xC3, ACK_A=1.
